imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Sequences and arbitrates the single address/write port of the instruction memory.
- Two requesters share the port: a program loader (word stream, valid/ready) and the CPU fetch path.
- On a load request the block validates the target window, streams words into consecutive word addresses and stalls fetch. It then returns the port to the CPU.

Parameters:
- RANGE, 32'h07ffffff, highest valid byte address of the instruction memory.
- CNT_W, 16, width of the word-count and progress counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_start  in  1  one-cycle load request; sampled in IDLE and ERR only
- ld_base  in  32  byte start address of load, sampled with ld_start
- ld_count  in  CNT_W  number of 32-bit words to load, sampled with ld_start
- ld_abort  in  1  abandon load in progress
- ld_valid  in  1  ld_data holds a word
- ld_data  in  32  program word, MSB byte stored at lowest address
- ld_ready  out  1  block accepts ld_data this cycle
- fetch_pc  in  32  CPU fetch address
- cpu_stall  out  1  fetch address not routed to memory; CPU must hold PC
- im_load  out  1  drives memory write enable (loadIM)
- im_addr  out  32  drives memory Address
- im_data  out  32  drives memory data
- ld_done  out  1  one-cycle pulse: load completed
- ld_err  out  1  sticky: last request rejected
- ld_words  out  CNT_W  words written by current or last load

Behaviour:
- States: IDLE, LOAD, DONE, ERR. Encoding is free; the state register is reset asynchronously to IDLE.
- Reset values:
  - state=IDLE, ld_ready=0, cpu_stall=0, im_load=0, ld_done=0, ld_err=0, ld_words=0.
  - Internal address register = 0, remaining count = 0.
- IDLE:
  - im_addr=fetch_pc, im_load=0, im_data=0, cpu_stall=0.
  - On ld_start:
    - If ld_base[1:0]!=0, go to ERR.
    - Else if ld_count!=0 and ld_base + 4*ld_count - 1 > RANGE, go to ERR. Compute in 33+ bits; no wrap.
    - Else if ld_count==0, go to DONE.
    - Else latch addr=ld_base and rem=ld_count, clear ld_words, go to LOAD.
- LOAD:
  - ld_ready=1 and cpu_stall=1, both combinational from state.
  - im_addr=addr, im_data=ld_data, im_load=ld_valid (combinational).
  - The memory writes on the same clock edge as the handshake.
  - Each accepted word: addr+=4, rem-=1, ld_words+=1.
  - When a word is accepted with rem==1, go to DONE.
  - ld_valid=0 stalls indefinitely; cpu_stall stays 1.
  - ld_abort has priority over a simultaneous ld_valid. The word is not written, im_load is forced 0 that cycle, and the state goes to IDLE with no ld_done; ld_words keeps its partial count.
  - ld_start during LOAD is ignored.
- DONE:
  - Lasts one cycle: ld_done=1, cpu_stall=1, im_load=0, ld_ready=0.
  - Next state is IDLE.
- ERR:
  - ld_err=1 and ld_done=0; memory is never written.
  - Fetch behaves as in IDLE (cpu_stall=0, im_addr=fetch_pc).
  - A new ld_start clears ld_err and is evaluated exactly as in IDLE.
- ld_err also clears on any ld_start that is accepted from IDLE.
- The last byte of a legal window may equal RANGE exactly.
- ld_words saturates at neither end; it is bounded by ld_count.
- rst_n asserted mid-LOAD:
  - Returns to IDLE immediately and drops im_load asynchronously.
  - Words already written remain in memory.

Test Plan:
- Basic load: ld_start, base=0x100, count=3, words 0x00000013/0x00100093/0x00208113 each with ld_valid=1 -> im_load on 3 consecutive cycles at addresses 0x100/0x104/0x108; ld_done pulses in the cycle after the third word; ld_words=3; cpu_stall=1 from LOAD entry through DONE, 0 afterwards with im_addr=fetch_pc.
- Bubbled stream: same load with ld_valid toggling 1,0,0,1,0,1 -> exactly 3 writes with no address skip; stall held throughout.
- Error checks:
  - base=0x102 -> ld_err=1, no im_load, cpu_stall=0.
  - base=0x07fffffc, count=2 -> ld_err=1.
  - base=0x07fffffc, count=1 -> one write, ld_done.
- Zero count: base=0x200, count=0 -> ld_done the next cycle, no write, ld_err=0.
- Abort: count=4, ld_abort asserted with the 3rd ld_valid -> 2 writes only, ld_words=2, no ld_done, IDLE the next cycle; ld_start ignored during LOAD.
- Reset mid-load: rst_n low during the 2nd word -> im_load=0 and cpu_stall=0 immediately; all outputs at reset values; a subsequent load of count=1 works normally.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
// Program-loader side of the instruction-memory port controller:
// the load request, the word stream and its handshake.
interface imem_load_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ld_start;
  logic [31:0]      ld_base;
  logic [CNT_W-1:0] ld_count;
  logic             ld_abort;
  logic             ld_valid;
  logic [31:0]      ld_data;
  logic             ld_ready;

  modport master (
    output ld_start, ld_base, ld_count, ld_abort, ld_valid, ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_start, ld_base, ld_count, ld_abort, ld_valid, ld_data,
    output ld_ready
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Arbitrates the instruction-memory address/write port between CPU fetch and a
// streaming program loader that writes a validated window of consecutive words.
module imem_load_ctrl #(
  parameter logic [31:0] RANGE = 32'h07ffffff,
  parameter int          CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_load_ctrl_if.slave      ld,
  input  logic [31:0]          fetch_pc,
  output logic                 cpu_stall,
  output logic                 im_load,
  output logic [31:0]          im_addr,
  output logic [31:0]          im_data,
  output logic                 ld_done,
  output logic                 ld_err,
  output logic [CNT_W-1:0]     ld_words
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [31:0]      addr, addr_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [CNT_W-1:0] words, words_nxt;

  logic             base_misaligned;
  logic             window_over;
  logic [33:0]      last_byte;

  // Last byte of the requested window, widened so a huge base+count cannot wrap.
  assign last_byte       = {2'b00, ld.ld_base}
                         + {{(32-CNT_W){1'b0}}, ld.ld_count, 2'b00}
                         - 34'd1;
  assign base_misaligned = (ld.ld_base[1:0] != 2'b00);
  assign window_over     = (ld.ld_count != '0) && (last_byte > {2'b00, RANGE});

  // NOTE: sequential state uses non-blocking assignments only, and the async
  // reset clears every register so im_load drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      rem   <= '0;
      words <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      rem   <= rem_nxt;
      words <= words_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    rem_nxt     = rem;
    words_nxt   = words;
    ld.ld_ready = 1'b0;
    cpu_stall   = 1'b0;
    im_load     = 1'b0;
    im_addr     = fetch_pc;
    im_data     = 32'h0;
    ld_done     = 1'b0;
    ld_err      = 1'b0;

    unique case (state)
      IDLE, ERR: begin
        ld_err = (state == ERR);
        if (ld.ld_start) begin
          if (base_misaligned || window_over) begin
            state_nxt = ERR;
          end else if (ld.ld_count == '0) begin
            state_nxt = DONE;
          end else begin
            addr_nxt  = ld.ld_base;
            rem_nxt   = ld.ld_count;
            words_nxt = '0;
            state_nxt = LOAD;
          end
        end
      end

      LOAD: begin
        ld.ld_ready = 1'b1;
        cpu_stall   = 1'b1;
        im_addr     = addr;
        im_data     = ld.ld_data;
        // Abort wins over a word offered in the same cycle; that word is dropped.
        if (ld.ld_abort) begin
          state_nxt = IDLE;
        end else begin
          im_load = ld.ld_valid;
          if (ld.ld_valid) begin
            addr_nxt  = addr + 32'd4;
            rem_nxt   = rem - CNT_ONE;
            words_nxt = words + CNT_ONE;
            if (rem == CNT_ONE) state_nxt = DONE;
          end
        end
      end

      DONE: begin
        cpu_stall = 1'b1;
        ld_done   = 1'b1;
        im_addr   = addr;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign ld_words = words;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: expected memory writes are queued when
// words are driven and popped by a monitor whenever the DUT asserts im_load.
module tb_imem_load_ctrl;

  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic             clk;
  logic             rst_n;
  logic [31:0]      fetch_pc;
  logic             cpu_stall;
  logic             im_load;
  logic [31:0]      im_addr;
  logic [31:0]      im_data;
  logic             ld_done;
  logic             ld_err;
  logic [CNT_W-1:0] ld_words;

  imem_load_ctrl_if #(.CNT_W(CNT_W)) ld_if ();

  imem_load_ctrl #(.RANGE(32'h07ffffff), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld        (ld_if.slave),
    .fetch_pc  (fetch_pc),
    .cpu_stall (cpu_stall),
    .im_load   (im_load),
    .im_addr   (im_addr),
    .im_data   (im_data),
    .ld_done   (ld_done),
    .ld_err    (ld_err),
    .ld_words  (ld_words)
  );

  int  total = 0;
  int  bad   = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] base, input logic [CNT_W-1:0] count);
    ld_if.ld_start = 1'b1;
    ld_if.ld_base  = base;
    ld_if.ld_count = count;
    step();
    ld_if.ld_start = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Write monitor: sampled on the falling edge, the write lands on the next rising edge.
  always @(negedge clk) begin
    if (ld_done === 1'b1) done_cnt++;
    if (im_load === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'h0, im_addr}, 64'hffff_ffff_ffff_ffff);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", {32'h0, im_addr}, {32'h0, w.addr});
        check("wr_data", {32'h0, im_data}, {32'h0, w.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_wr;
    int exp_done;
    exp_wr   = 0;
    exp_done = 0;

    rst_n          = 1'b0;
    fetch_pc       = 32'h0000_0040;
    ld_if.ld_start = 1'b0;
    ld_if.ld_base  = 32'h0;
    ld_if.ld_count = '0;
    ld_if.ld_abort = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 32'h0;

    // Reset state
    #2;
    check("rst_ready",  {63'h0, ld_if.ld_ready}, 64'h0);
    check("rst_stall",  {63'h0, cpu_stall}, 64'h0);
    check("rst_im_load",{63'h0, im_load}, 64'h0);
    check("rst_done",   {63'h0, ld_done}, 64'h0);
    check("rst_err",    {63'h0, ld_err}, 64'h0);
    check("rst_words",  {48'h0, ld_words}, 64'h0);
    check("rst_im_addr",{32'h0, im_addr}, 64'h40);
    #10 rst_n = 1'b1;
    step();

    // Basic load: three words back to back
    push_wr(32'h100, 32'h0000_0013);
    push_wr(32'h104, 32'h0010_0093);
    push_wr(32'h108, 32'h0020_8113);
    exp_wr += 3;
    start_load(32'h100, 16'd3);
    check("basic_stall_entry", {63'h0, cpu_stall}, 64'h1);
    check("basic_ready",       {63'h0, ld_if.ld_ready}, 64'h1);
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'h0000_0013; step();
    ld_if.ld_data = 32'h0010_0093; step();
    ld_if.ld_data = 32'h0020_8113; step();
    ld_if.ld_valid = 1'b0;
    exp_done++;
    check("basic_done",       {63'h0, ld_done}, 64'h1);
    check("basic_done_stall", {63'h0, cpu_stall}, 64'h1);
    check("basic_done_noload",{63'h0, im_load}, 64'h0);
    check("basic_done_ready", {63'h0, ld_if.ld_ready}, 64'h0);
    check("basic_words",      {48'h0, ld_words}, 64'd3);
    step();
    check("basic_idle_stall", {63'h0, cpu_stall}, 64'h0);
    check("basic_idle_done",  {63'h0, ld_done}, 64'h0);
    check("basic_idle_addr",  {32'h0, im_addr}, 64'h40);
    check("basic_wr_cnt",     64'(wr_cnt), 64'(exp_wr));
    check("basic_done_cnt",   64'(done_cnt), 64'(exp_done));

    // Bubbled stream: valid pattern 1,0,0,1,0,1
    push_wr(32'h100, 32'h1111_0001);
    push_wr(32'h104, 32'h1111_0002);
    push_wr(32'h108, 32'h1111_0003);
    exp_wr += 3;
    start_load(32'h100, 16'd3);
    begin
      logic [5:0] pat;
      int k;
      pat = 6'b101001;
      k   = 1;
      for (int i = 0; i < 6; i++) begin
        ld_if.ld_valid = pat[i];
        ld_if.ld_data  = pat[i] ? (32'h1111_0000 + 32'(k)) : 32'hdead_beef;
        if (pat[i]) k++;
        #1;
        check("bubble_stall", {63'h0, cpu_stall}, 64'h1);
        step();
      end
    end
    ld_if.ld_valid = 1'b0;
    exp_done++;
    check("bubble_done",  {63'h0, ld_done}, 64'h1);
    check("bubble_words", {48'h0, ld_words}, 64'd3);
    step();
    check("bubble_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
    check("bubble_q_empty", 64'(exp_q.size()), 64'd0);

    // Misaligned base -> ERR, fetch keeps the port
    fetch_pc = 32'h0000_0088;
    start_load(32'h102, 16'd1);
    check("mis_err",   {63'h0, ld_err}, 64'h1);
    check("mis_stall", {63'h0, cpu_stall}, 64'h0);
    check("mis_ready", {63'h0, ld_if.ld_ready}, 64'h0);
    check("mis_addr",  {32'h0, im_addr}, 64'h88);
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'hbad0_bad0;
    step();
    ld_if.ld_valid = 1'b0;
    check("mis_noload", {63'h0, im_load}, 64'h0);
    check("mis_err_sticky", {63'h0, ld_err}, 64'h1);

    // Window one word past RANGE -> ERR again (evaluated from ERR)
    start_load(32'h07ff_fffc, 16'd2);
    check("over_err",   {63'h0, ld_err}, 64'h1);
    check("over_stall", {63'h0, cpu_stall}, 64'h0);

    // Window ending exactly at RANGE is legal
    push_wr(32'h07ff_fffc, 32'hcafe_f00d);
    exp_wr++;
    start_load(32'h07ff_fffc, 16'd1);
    check("edge_err_clr", {63'h0, ld_err}, 64'h0);
    check("edge_stall",   {63'h0, cpu_stall}, 64'h1);
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'hcafe_f00d; step();
    ld_if.ld_valid = 1'b0;
    exp_done++;
    check("edge_done",  {63'h0, ld_done}, 64'h1);
    check("edge_words", {48'h0, ld_words}, 64'd1);
    step();
    check("edge_wr_cnt", 64'(wr_cnt), 64'(exp_wr));

    // Zero count -> DONE with no write
    start_load(32'h200, 16'd0);
    exp_done++;
    check("zero_done",   {63'h0, ld_done}, 64'h1);
    check("zero_noload", {63'h0, im_load}, 64'h0);
    check("zero_err",    {63'h0, ld_err}, 64'h0);
    step();
    check("zero_done_end", {63'h0, ld_done}, 64'h0);
    check("zero_wr_cnt",   64'(wr_cnt), 64'(exp_wr));

    // Abort with the third word; ld_start during LOAD is ignored
    push_wr(32'h300, 32'haaaa_0001);
    push_wr(32'h304, 32'haaaa_0002);
    exp_wr += 2;
    start_load(32'h300, 16'd4);
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'haaaa_0001; step();
    ld_if.ld_data  = 32'haaaa_0002;
    ld_if.ld_start = 1'b1; ld_if.ld_base = 32'h102; ld_if.ld_count = 16'd1;
    step();
    ld_if.ld_start = 1'b0;
    check("abort_start_ignored", {63'h0, ld_err}, 64'h0);
    check("abort_still_stall",   {63'h0, cpu_stall}, 64'h1);
    ld_if.ld_data = 32'haaaa_0003; ld_if.ld_abort = 1'b1;
    #1;
    check("abort_masks_load", {63'h0, im_load}, 64'h0);
    step();
    ld_if.ld_abort = 1'b0; ld_if.ld_valid = 1'b0;
    check("abort_idle_stall", {63'h0, cpu_stall}, 64'h0);
    check("abort_no_done",    {63'h0, ld_done}, 64'h0);
    check("abort_words",      {48'h0, ld_words}, 64'd2);
    check("abort_addr",       {32'h0, im_addr}, 64'h88);
    step();
    check("abort_wr_cnt",   64'(wr_cnt), 64'(exp_wr));
    check("abort_done_cnt", 64'(done_cnt), 64'(exp_done));

    // Reset during the second word
    push_wr(32'h400, 32'hbbbb_0001);
    exp_wr++;
    start_load(32'h400, 16'd3);
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'hbbbb_0001; step();
    ld_if.ld_data = 32'hbbbb_0002;
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_im_load", {63'h0, im_load}, 64'h0);
    check("rstmid_stall",   {63'h0, cpu_stall}, 64'h0);
    check("rstmid_ready",   {63'h0, ld_if.ld_ready}, 64'h0);
    check("rstmid_words",   {48'h0, ld_words}, 64'd0);
    check("rstmid_addr",    {32'h0, im_addr}, 64'h88);
    ld_if.ld_valid = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    check("rstmid_wr_cnt", 64'(wr_cnt), 64'(exp_wr));

    push_wr(32'h500, 32'hcccc_0001);
    exp_wr++;
    start_load(32'h500, 16'd1);
    check("post_rst_stall", {63'h0, cpu_stall}, 64'h1);
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'hcccc_0001; step();
    ld_if.ld_valid = 1'b0;
    exp_done++;
    check("post_rst_done",  {63'h0, ld_done}, 64'h1);
    check("post_rst_words", {48'h0, ld_words}, 64'd1);
    step();
    step();
    check("final_wr_cnt",   64'(wr_cnt), 64'(exp_wr));
    check("final_done_cnt", 64'(done_cnt), 64'(exp_done));
    check("final_q_empty",  64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
